// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access-size encodings,
// FSM state encoding and default geometry/timing constants.
package dmem_pkg;

  localparam int DEFAULT_DEPTH_WORDS = 64;
  localparam int DEFAULT_WAIT_CYCLES = 2;

  localparam logic [1:0] SIZE_W   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_B   = 2'b10;
  localparam logic [1:0] SIZE_RSV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the CPU data port (master) and the
// memory responder (slave).
interface dmem_responder_if #(
  parameter int XLEN = 32
);

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;
  logic            busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering for one 32-bit memory word: byte-write mask and
// replicated store data on the write side, lane select plus sign/zero
// extension on the read side, and the alignment check for the access size.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      size,
  input  logic [1:0]      addr_lo,
  input  logic            is_unsigned,
  input  logic [31:0]     rword,
  input  logic [XLEN-1:0] wdata,
  output logic [3:0]      be,
  output logic [31:0]     wdata_lane,
  output logic [XLEN-1:0] rdata_ext,
  output logic            misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rword[8*addr_lo +: 8];
  assign half_sel = addr_lo[1] ? rword[31:16] : rword[15:0];

  // Decode mask, steered write data and extended read data from the size.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    be         = 4'b0000;
    wdata_lane = '0;
    rdata_ext  = '0;
    misalign   = 1'b0;
    case (size)
      SIZE_W: begin
        be         = 4'b1111;
        wdata_lane = wdata[31:0];
        rdata_ext  = XLEN'(rword);
        misalign   = (addr_lo != 2'b00);
      end
      SIZE_H: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = is_unsigned ? XLEN'(half_sel) : XLEN'($signed(half_sel));
        misalign   = addr_lo[0];
      end
      SIZE_B: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = is_unsigned ? XLEN'(byte_sel) : XLEN'($signed(byte_sel));
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one request at a time, waits
// WAIT_CYCLES cycles, commits the load/store with lane steering and returns
// the result over a response handshake.
// Optional macro DMEM_DEBUG_PORT_EN adds a combinational word-read debug port.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  dmem_responder_if.slave bus
`ifdef DMEM_DEBUG_PORT_EN
  ,
  input  logic [5:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
`endif
);

  localparam int          IDX_W      = $clog2(DEPTH_WORDS);
  localparam int unsigned BYTE_LIMIT = DEPTH_WORDS * 4;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

  logic [31:0]      mem_q [DEPTH_WORDS];
  logic [IDX_W-1:0] word_idx;
  logic             in_range;
  logic             acc_err;
  logic             wr_en;
  logic [3:0]       be;
  logic [31:0]      wdata_lane;
  logic [XLEN-1:0]  rdata_ext;
  logic             misalign;

  assign word_idx = addr_q[IDX_W+1:2];
  assign in_range = (addr_q < XLEN'(BYTE_LIMIT));
  assign acc_err  = (size_q == SIZE_RSV) || misalign || !in_range;

  dmem_lane_align #(.XLEN(XLEN)) u_align (
    .size       (size_q),
    .addr_lo    (addr_q[1:0]),
    .is_unsigned(uns_q),
    .rword      (mem_q[word_idx]),
    .wdata      (wdata_q),
    .be         (be),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext),
    .misalign   (misalign)
  );

  // Next-state, request capture, commit and response formation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    uns_d       = uns_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    wr_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          wr_en       = we_q && !acc_err;
          rsp_valid_d = 1'b1;
          rsp_err_d   = acc_err;
          rsp_rdata_d = (acc_err || we_q) ? '0 : rdata_ext;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, latched request and registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= SIZE_W;
      uns_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage array with per-byte write enables.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the array is cleared on reset, so it maps to flops, not SRAM.
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[word_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
      end
    end
  end

  assign bus.req_ready = (state_q == IDLE) && !rst;
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

`ifdef DMEM_DEBUG_PORT_EN
  assign dbg_data = (32'(dbg_addr) < 32'(DEPTH_WORDS)) ? XLEN'(mem_q[dbg_addr]) : '0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed plan scenarios plus
// randomized traffic against a byte-array reference model.
module tb_dmem_responder;

  localparam int XLEN  = 32;
  localparam int DEPTH = 64;
  localparam int WAITC = 2;
  localparam int LAT   = WAITC + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] mm [0:DEPTH*4-1];

  dmem_responder_if #(.XLEN(XLEN)) bus ();

  dmem_responder #(.XLEN(XLEN), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference: byte-addressed memory, errors from the access rules.
  function automatic void model(input logic we, input int unsigned addr, input logic [31:0] wdata,
                                input logic [1:0] size, input logic uns,
                                output logic [31:0] rd, output logic er);
    int unsigned n;
    longint unsigned v;
    n  = (size == 2'd0) ? 4 : (size == 2'd1) ? 2 : 1;
    er = (size == 2'd3) || (size == 2'd0 && addr % 4 != 0) ||
         (size == 2'd1 && addr % 2 != 0) || (addr >= DEPTH * 4);
    rd = 32'h0;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < int'(n); i++) mm[addr + i] = wdata[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < int'(n); i++) v = v + (longint'(mm[addr + i]) << (8 * i));
        if (!uns && n < 4 && mm[addr + n - 1][7]) v = v + (64'h1_0000_0000 - (64'h1 << (8 * n)));
        rd = v[31:0];
      end
    end
  endfunction

  task automatic start_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] size, input logic uns, output int lat);
    int n;
    @(negedge clk);
    bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wdata;
    bus.req_size = size; bus.req_unsigned = uns; bus.req_valid = 1'b1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      errors++; $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, required 1", bus.rsp_valid, lat);
    end
  endtask

  task automatic finish_rsp;
    @(negedge clk); bus.rsp_ready = 1'b1;
    @(posedge clk); #1; bus.rsp_ready = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < DEPTH * 4; i++) mm[i] = 8'h0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || bus.busy !== 1'b0 || bus.rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_outputs: valid=%b err=%b busy=%b rdata=%h want 0", bus.rsp_valid, bus.rsp_err, bus.busy, bus.rsp_rdata);
    end
    do_reset();
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_word;
    int lat;
    start_req(1'b1, 32'h10, 32'hDEADBEEF, 2'b00, 1'b0, lat);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL word_latency: got %0d want %0d", lat, LAT); end
    checks++; if (bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL word_store_rsp: err=%b rdata=%h want 0/0", bus.rsp_err, bus.rsp_rdata);
    end
    finish_rsp();
    start_req(1'b0, 32'h10, 32'h0, 2'b00, 1'b0, lat);
    checks++; if (bus.rsp_rdata !== 32'hDEADBEEF || bus.rsp_err !== 1'b0) begin
      errors++; $display("FAIL word_load: rdata=%h err=%b want deadbeef/0", bus.rsp_rdata, bus.rsp_err);
    end
    finish_rsp();
  endtask

  task automatic test_byte;
    int lat;
    start_req(1'b1, 32'h13, 32'h00000080, 2'b10, 1'b0, lat); finish_rsp();
    start_req(1'b0, 32'h10, 32'h0, 2'b00, 1'b0, lat);
    checks++; if (bus.rsp_rdata !== 32'h80ADBEEF) begin errors++; $display("FAIL byte_merge: got %h want 80adbeef", bus.rsp_rdata); end
    finish_rsp();
    start_req(1'b0, 32'h13, 32'h0, 2'b10, 1'b0, lat);
    checks++; if (bus.rsp_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL byte_signed: got %h want ffffff80", bus.rsp_rdata); end
    finish_rsp();
    start_req(1'b0, 32'h13, 32'h0, 2'b10, 1'b1, lat);
    checks++; if (bus.rsp_rdata !== 32'h00000080) begin errors++; $display("FAIL byte_unsigned: got %h want 00000080", bus.rsp_rdata); end
    finish_rsp();
  endtask

  task automatic test_half;
    int lat;
    start_req(1'b1, 32'h22, 32'hABCD1234, 2'b01, 1'b0, lat); finish_rsp();
    start_req(1'b0, 32'h22, 32'h0, 2'b01, 1'b0, lat);
    checks++; if (bus.rsp_rdata !== 32'h00001234) begin errors++; $display("FAIL half_load: got %h want 00001234", bus.rsp_rdata); end
    finish_rsp();
    start_req(1'b0, 32'h20, 32'h0, 2'b00, 1'b0, lat);
    checks++; if (bus.rsp_rdata !== 32'h12340000) begin errors++; $display("FAIL half_lanes: got %h want 12340000", bus.rsp_rdata); end
    finish_rsp();
  endtask

  task automatic test_errors;
    int lat;
    start_req(1'b0, 32'h06, 32'h0, 2'b00, 1'b0, lat);
    checks++; if (bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL err_misalign: err=%b rdata=%h want 1/0", bus.rsp_err, bus.rsp_rdata);
    end
    finish_rsp();
    start_req(1'b1, 32'h100, 32'hFFFFFFFF, 2'b00, 1'b0, lat);
    checks++; if (bus.rsp_err !== 1'b1) begin errors++; $display("FAIL err_range: err=%b want 1", bus.rsp_err); end
    finish_rsp();
    start_req(1'b0, 32'h00, 32'h0, 2'b00, 1'b0, lat);
    checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL err_range_nowrite: word0=%h want 0", bus.rsp_rdata); end
    finish_rsp();
    start_req(1'b0, 32'h10, 32'h0, 2'b11, 1'b0, lat);
    checks++; if (bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL err_size: err=%b rdata=%h want 1/0", bus.rsp_err, bus.rsp_rdata);
    end
    finish_rsp();
  endtask

  task automatic test_backpressure;
    int lat;
    start_req(1'b0, 32'h10, 32'h0, 2'b00, 1'b0, lat);
    // A competing store must be ignored while the response is pending.
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h10;
    bus.req_wdata = 32'h0; bus.req_size = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h80ADBEEF || bus.rsp_err !== 1'b0 || bus.req_ready !== 1'b0) begin
        errors++; $display("FAIL backpressure_hold[%0d]: valid=%b rdata=%h err=%b ready=%b want 1/80adbeef/0/0",
                           i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.req_ready);
      end
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1; bus.rsp_ready = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL same_cycle_accept: busy=%b valid=%b rdata=%h want 0/0/0", bus.busy, bus.rsp_valid, bus.rsp_rdata);
    end
    // Request held across the handshake is accepted on the following edge.
    bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_addr = 32'h10;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", bus.req_ready); end
    @(posedge clk); #1; bus.req_valid = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy=%b want 1", bus.busy); end
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== LAT || bus.rsp_rdata !== 32'h80ADBEEF) begin
      errors++; $display("FAIL b2b_load: lat=%0d rdata=%h want %0d/80adbeef", lat, bus.rsp_rdata, LAT);
    end
    finish_rsp();
  endtask

  task automatic test_reset_mid_op;
    int lat;
    @(negedge clk);
    bus.req_we = 1'b1; bus.req_addr = 32'h30; bus.req_wdata = 32'hCAFEF00D;
    bus.req_size = 2'b00; bus.req_valid = 1'b1;
    @(posedge clk); #1; bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    checks++; if (bus.busy !== 1'b0 || bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_wait: busy=%b ready=%b valid=%b rdata=%h want 0", bus.busy, bus.req_ready, bus.rsp_valid, bus.rsp_rdata);
    end
    @(negedge clk); rst = 1'b0;
    start_req(1'b0, 32'h30, 32'h0, 2'b00, 1'b0, lat);
    checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_nowrite: got %h want 0", bus.rsp_rdata); end
    finish_rsp();
    start_req(1'b0, 32'h10, 32'h0, 2'b00, 1'b0, lat);
    checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_clear: got %h want 0", bus.rsp_rdata); end
    // Reset while the response is pending drops it.
    @(negedge clk); rst = 1'b1; #1;
    checks++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_resp: valid=%b busy=%b want 0/0", bus.rsp_valid, bus.busy);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_random;
    int lat;
    logic we, uns, exp_er;
    logic [1:0] size;
    logic [31:0] addr, wdata, exp_rd;
    do_reset();
    for (int t = 0; t < 40; t++) begin
      we    = 1'($urandom_range(0, 1));
      uns   = 1'($urandom_range(0, 1));
      size  = 2'($urandom_range(0, 3));
      wdata = $urandom;
      addr  = $urandom_range(0, 63);
      if ($urandom_range(0, 3) != 0) addr = (size == 2'd0) ? (addr & ~32'h3) : (size == 2'd1) ? (addr & ~32'h1) : addr;
      if ($urandom_range(0, 9) == 0) addr = 32'h100 + $urandom_range(0, 255);
      model(we, addr, wdata, size, uns, exp_rd, exp_er);
      start_req(we, addr, wdata, size, uns, lat);
      checks++; if (lat !== LAT) begin errors++; $display("FAIL rand_lat[%0d]: got %0d want %0d", t, lat, LAT); end
      checks++; if (bus.rsp_err !== exp_er) begin errors++; $display("FAIL rand_err[%0d]: got %b want %b", t, bus.rsp_err, exp_er); end
      checks++; if (bus.rsp_rdata !== exp_rd) begin errors++; $display("FAIL rand_rdata[%0d]: got %h want %h", t, bus.rsp_rdata, exp_rd); end
      finish_rsp();
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.req_size = 2'b00; bus.req_unsigned = 1'b0; bus.rsp_ready = 1'b0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
